// File: rtl/mac_4_pipe.sv
// -----------------------------------------------------------------------------
// mac_4_pipe
//   Two-stage pipelined multiply-accumulate engine with valid/ready handshakes
//   on both sides:  out = (a*b + addend) mod 2^DATA_WIDTH, where addend is c,
//   the previous result (accumulate mode) or zero (accumulator clear).
//
//   Stage S1 registers the full-width product and the addend selection.
//   Stage S2 adds the addend, registers the truncated result and overflow flag,
//   and updates the accumulator. Each stage carries its own valid bit.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operand beat valid            in_ready   engine accepts a beat
//   a, b, c    unsigned operands             acc_en     addend = accumulator
//   acc_clr    addend = 0, overrides acc_en
//   out_valid  result beat valid             out_ready  downstream accepts
//   out        truncated result              ovf        full sum exceeded W bits
// -----------------------------------------------------------------------------
module mac_4_pipe #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] c,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  ovf
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;

  // Addend source, decoded once when the beat enters S1.
  typedef enum logic [1:0] {
    ADD_C    = 2'd0,
    ADD_ACC  = 2'd1,
    ADD_ZERO = 2'd2
  } add_sel_e;

  // Stage S1
  logic          s1_valid_q;
  logic [PW-1:0] s1_prod_q;
  logic [W-1:0]  s1_c_q;
  add_sel_e      s1_sel_q;

  // Stage S2 / output
  logic          out_valid_q;
  logic [W-1:0]  out_q;
  logic          ovf_q;
  logic [W-1:0]  acc_q;

  // Handshake / advance
  logic          s2_adv;
  logic          s1_adv;
  logic          s1_load;
  logic          s2_load;

  // S2 datapath
  logic [W-1:0]  addend_d;
  logic [PW:0]   full_d;
  add_sel_e      sel_d;

  // S2 may take a new beat when it is empty or its beat is leaving this edge;
  // S1 may take one when it is empty or its beat moves into S2.
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && !rst;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_adv;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    sel_d = ADD_C;
    if (acc_clr)     sel_d = ADD_ZERO;
    else if (acc_en) sel_d = ADD_ACC;
  end

  always_comb begin
    addend_d = s1_c_q;
    case (s1_sel_q)
      ADD_ACC:  addend_d = acc_q;
      ADD_ZERO: addend_d = '0;
      default:  addend_d = s1_c_q;
    endcase
    full_d = {1'b0, s1_prod_q} + {{(PW + 1 - W){1'b0}}, addend_d};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_c_q      <= '0;
      s1_sel_q    <= ADD_C;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= 1'b1;
        s1_prod_q  <= PW'(a) * PW'(b);
        s1_c_q     <= c;
        s1_sel_q   <= sel_d;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end

      // acc_q moves only with a real S2 load, so bubbles leave it untouched
      // and a following accumulate beat always sees its predecessor's result.
      if (s2_load) begin
        out_valid_q <= 1'b1;
        out_q       <= full_d[W-1:0];
        ovf_q       <= |full_d[PW:W];
        acc_q       <= full_d[W-1:0];
      end else if (s2_adv) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_4_pipe.sv
// -----------------------------------------------------------------------------
// tb_mac_4_pipe
//   Self-checking bench for mac_4_pipe (DATA_WIDTH=4). A transaction-level
//   model keeps a queue of expected results in acceptance order, computed with
//   plain arithmetic, plus the acceptance edge of each beat. A single monitor
//   on the falling edge compares out_valid, in_ready, out and ovf against it
//   every cycle. Directed sequences pin the model with literal results.
// -----------------------------------------------------------------------------
module tb_mac_4_pipe;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] c = '0;
  logic         acc_en = 1'b0;
  logic         acc_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         ovf;

  mac_4_pipe #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .acc_en   (acc_en),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           edge_n;  // index of the rising edge that accepted the beat
  } exp_t;

  exp_t         pend[$];
  int           m_acc   = 0;
  int           cyc     = 0;
  int           acc_cnt = 0;
  bit           armed   = 0;
  logic [W-1:0] log_out[$];
  logic         log_ovf[$];
  int           log_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit   exp_valid;
    bit   exp_ready;
    int   addend;
    int   full;
    exp_t e;
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      pend.delete();
      m_acc = 0;
      armed = 1;
    end else if (armed) begin
      // At this falling edge `cyc` rising edges have happened; the front beat
      // becomes visible one edge after the edge that accepted it.
      exp_valid = (pend.size() > 0) && (cyc >= pend[0].edge_n + 1);
      exp_ready = (pend.size() < 2) || out_ready;
      check("out_valid", out_valid, exp_valid);
      check("in_ready", in_ready, exp_ready);
      if (exp_valid) begin
        check("out", out, pend[0].res);
        check("ovf", ovf, pend[0].ovf);
        if (out_ready) begin
          log_out.push_back(out);
          log_ovf.push_back(ovf);
          log_cyc.push_back(cyc);
          void'(pend.pop_front());
        end
      end
      if (in_valid && exp_ready) begin
        if (acc_clr)     addend = 0;
        else if (acc_en) addend = m_acc;
        else             addend = int'(c);
        full     = int'(a) * int'(b) + addend;
        e.res    = W'(full % 16);
        e.ovf    = (full > 15);
        e.edge_n = cyc + 1;
        m_acc    = full % 16;
        pend.push_back(e);
        acc_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic send(input int ia, input int ib, input int ic, input bit en, input bit clr);
    int n;
    a = W'(ia); b = W'(ib); c = W'(ic);
    acc_en = en; acc_clr = clr;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 60) begin
        fail_timeout("send_accept");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (pend.size() > 0 || out_valid) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        fail_timeout("drain");
        break;
      end
    end
  endtask

  task automatic clear_log();
    log_out.delete();
    log_ovf.delete();
    log_cyc.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [W-1:0] hold_out;
  logic         hold_ovf;
  int           base;
  int           ta[10];
  int           tb_[10];
  int           tc[10];
  bit           rnd_done;

  initial begin
    // 1 Reset held two cycles with in_valid high
    rst = 1'b1; in_valid = 1'b1; a = 4'd5; b = 4'd5; c = 4'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // 2 Basic results
    clear_log();
    send(3, 2, 1, 0, 0);
    send(3, 4, 5, 0, 0);
    send(15, 15, 15, 0, 0);
    wait_idle();
    check("basic_count", log_out.size(), 3);
    if (log_out.size() == 3) begin
      check("basic0_out", log_out[0], 7);  check("basic0_ovf", log_ovf[0], 0);
      check("basic1_out", log_out[1], 1);  check("basic1_ovf", log_ovf[1], 1);
      check("basic2_out", log_out[2], 0);  check("basic2_ovf", log_ovf[2], 1);
    end

    // 3 Accumulate chain, back-to-back
    clear_log();
    send(2, 3, 9, 0, 1);
    send(1, 4, 9, 1, 0);
    send(2, 2, 9, 1, 0);
    send(1, 3, 9, 1, 0);
    wait_idle();
    check("acc_count", log_out.size(), 4);
    if (log_out.size() == 4) begin
      check("acc0_out", log_out[0], 6);
      check("acc1_out", log_out[1], 10);
      check("acc2_out", log_out[2], 14);
      check("acc3_out", log_out[3], 1);
      check("acc3_ovf", log_ovf[3], 1);
      check("acc_b2b", log_cyc[3] - log_cyc[0], 3);
    end

    // 4 Backpressure: only two beats fit while the output is stalled
    clear_log();
    out_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        send(1, 1, 1, 0, 0);
        send(2, 2, 2, 0, 0);
        send(3, 3, 3, 0, 0);
        send(4, 4, 4, 0, 0);
      end
    join_none
    repeat (6) @(negedge clk);
    #1;
    check("bp_accepted", acc_cnt - base, 2);
    check("bp_in_ready", in_ready, 0);
    hold_out = out; hold_ovf = ovf;
    repeat (3) @(negedge clk);
    #1;
    check("bp_out_stable", out, hold_out);
    check("bp_ovf_stable", ovf, hold_ovf);
    check("bp_out_first", out, 2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    wait_idle();
    check("bp_count", log_out.size(), 4);
    if (log_out.size() == 4) begin
      check("bp0_out", log_out[0], 2);
      check("bp1_out", log_out[1], 6);
      check("bp2_out", log_out[2], 12);
      check("bp3_out", log_out[3], 4);
      check("bp3_ovf", log_ovf[3], 1);
    end

    // 5 Throughput: ten random beats, one result per cycle
    clear_log();
    for (int i = 0; i < 10; i++) begin
      ta[i] = $urandom_range(15); tb_[i] = $urandom_range(15); tc[i] = $urandom_range(15);
    end
    for (int i = 0; i < 10; i++) send(ta[i], tb_[i], tc[i], 0, 0);
    wait_idle();
    check("tp_count", log_out.size(), 10);
    if (log_out.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        check("tp_out", log_out[i], (ta[i] * tb_[i] + tc[i]) % 16);
        check("tp_ovf", log_ovf[i], (ta[i] * tb_[i] + tc[i]) > 15);
        if (i > 0) check("tp_consecutive", log_cyc[i] - log_cyc[i-1], 1);
      end
    end

    // Randomized traffic with random backpressure, bubbles and modes
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          int gap;
          gap = $urandom_range(3);
          if (gap == 0) repeat ($urandom_range(2) + 1) @(posedge clk);
          #1;
          send($urandom_range(15), $urandom_range(15), $urandom_range(15),
               ($urandom_range(2) != 0), ($urandom_range(9) == 0));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();

    // 6 Reset while two beats are stalled
    clear_log();
    out_ready = 1'b0;
    send(1, 2, 3, 0, 0);
    send(2, 2, 1, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_ovf", ovf, 0);
    out_ready = 1'b1;
    send(2, 3, 7, 1, 0);
    wait_idle();
    check("mid_rst_count", log_out.size(), 1);
    if (log_out.size() == 1) check("mid_rst_acc_out", log_out[0], 6);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
